// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and register packing helpers.
package cp0_exception_unit_pkg;

  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;
  localparam logic [4:0] RegPrid  = 5'd15;

  localparam int unsigned SrIe    = 0;
  localparam int unsigned SrExl   = 1;
  localparam int unsigned ImLsb   = 10;
  localparam int unsigned ImMsb   = 15;
  localparam int unsigned CauseBd = 31;
  localparam int unsigned ExcLsb  = 2;
  localparam int unsigned ExcMsb  = 6;

  typedef enum logic [4:0] {
    ExcInt  = 5'd0,
    ExcAdEL = 5'd4,
    ExcAdES = 5'd5,
    ExcRI   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

  function automatic logic [31:0] pack_sr(logic [5:0] im, logic exl, logic ie);
    logic [31:0] r;
    r              = '0;
    r[ImMsb:ImLsb] = im;
    r[SrExl]       = exl;
    r[SrIe]        = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(logic bd, logic [5:0] ip, logic [4:0] code);
    logic [31:0] r;
    r                = '0;
    r[CauseBd]       = bd;
    r[ImMsb:ImLsb]   = ip;
    r[ExcMsb:ExcLsb] = code;
    return r;
  endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// M-stage pipeline <-> CP0 signal bundle (mfc0/mtc0, exception inputs, redirect outputs).
interface cp0_exception_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        Exc_M;
  logic [4:0]  ExcCode_M;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] NPC_Exc;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC_M, BD_M, Exc_M, ExcCode_M, EXLClr, HWInt,
    input  IntReq, NPC_Exc, EPC_out, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC_M, BD_M, Exc_M, ExcCode_M, EXLClr, HWInt,
    output IntReq, NPC_Exc, EPC_out, DOut
  );
endinterface

// File: rtl/cp0_int_arbiter.sv
// Combinational exception/interrupt arbitration: request, selected code and
// word-aligned return address.
module cp0_int_arbiter
  import cp0_exception_unit_pkg::*;
(
  input  logic        en,
  input  logic [5:0]  hw_int,
  input  logic [5:0]  im,
  input  logic        ie,
  input  logic        exl,
  input  logic        exc,
  input  logic [4:0]  exc_code_in,
  input  logic [31:0] pc_eff,
  input  logic        bd_eff,
  output logic        int_req,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_val
);

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] epc_raw;

  always_comb begin
    int_pend = (|(hw_int & im)) & ie & ~exl;
    exc_pend = exc & ~exl;
    int_req  = en & (int_pend | exc_pend);
    // Interrupts take priority over the synchronous exception.
    exc_code = int_pend ? ExcInt : exc_code_in;
    epc_raw  = bd_eff ? (pc_eff - 32'd4) : pc_eff;
    epc_val  = epc_raw & ~32'h3;
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PrID state, mfc0/mtc0, eret and
// exception/interrupt redirect.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h4255_4141,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic                 clk,
  input logic                 reset,
  cp0_exception_unit_if.slave bus
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        last_bd_q, last_bd_d;

  logic        pc_valid;
  logic [31:0] pc_eff;
  logic        bd_eff;
  logic        int_req;
  logic [4:0]  sel_code;
  logic [31:0] epc_val;

  // A zero PC is a bubble; fall back to the last real instruction.
  assign pc_valid = (bus.PC_M != 32'd0);
  assign pc_eff   = pc_valid ? bus.PC_M : last_pc_q;
  assign bd_eff   = pc_valid ? bus.BD_M : last_bd_q;

  cp0_int_arbiter u_arbiter (
    .en          (reset),
    .hw_int      (bus.HWInt),
    .im          (sr_im_q),
    .ie          (sr_ie_q),
    .exl         (sr_exl_q),
    .exc         (bus.Exc_M),
    .exc_code_in (bus.ExcCode_M),
    .pc_eff      (pc_eff),
    .bd_eff      (bd_eff),
    .int_req     (int_req),
    .exc_code    (sel_code),
    .epc_val     (epc_val)
  );

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    last_pc_d   = pc_valid ? bus.PC_M : last_pc_q;
    last_bd_d   = pc_valid ? bus.BD_M : last_bd_q;
    if (int_req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_eff;
      cause_exc_d = sel_code;
      epc_d       = epc_val;
    end else begin
      if (bus.WE && bus.A2 == RegSr) begin
        sr_im_d  = bus.DIn[ImMsb:ImLsb];
        sr_exl_d = bus.DIn[SrExl];
        sr_ie_d  = bus.DIn[SrIe];
      end
      if (bus.WE && bus.A2 == RegEpc) begin
        epc_d = bus.DIn;
      end
      // eret wins over a same-cycle SR write of EXL.
      if (bus.EXLClr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= 6'h3F;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b1;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'h00;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
      last_pc_q   <= 32'h0000_3000;
      last_bd_q   <= 1'b0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= bus.HWInt;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
      last_pc_q   <= last_pc_d;
      last_bd_q   <= last_bd_d;
    end
  end

  always_comb begin
    unique case (bus.A1)
      RegSr:    bus.DOut = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
      RegCause: bus.DOut = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
      RegEpc:   bus.DOut = epc_q;
      RegPrid:  bus.DOut = PRID;
      default:  bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq  = int_req;
  assign bus.NPC_Exc = HANDLER_PC;
  assign bus.EPC_out = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed, table-driven bench for cp0_exception_unit; one row per clock cycle.
module tb_cp0_exception_unit;

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
    logic        eret;
    logic [5:0]  hw;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
    logic [2:0]  ck;  // [0] IntReq, [1] DOut, [2] EPC_out
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t vq[$];

  cp0_exception_unit_if bus ();

  cp0_exception_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [4:0] a1, input logic we,
                     input logic [4:0] a2, input logic [31:0] din, input logic [31:0] pc,
                     input logic bd, input logic exc, input logic [4:0] code,
                     input logic eret, input logic [5:0] hw, input logic req,
                     input logic [31:0] dout, input logic [31:0] epc, input logic [2:0] ck);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.we = we; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.code = code; v.eret = eret; v.hw = hw; v.req = req; v.dout = dout;
    v.epc = epc; v.ck = ck;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    bus.A1        = v.a1;
    bus.WE        = v.we;
    bus.A2        = v.a2;
    bus.DIn       = v.din;
    bus.PC_M      = v.pc;
    bus.BD_M      = v.bd;
    bus.Exc_M     = v.exc;
    bus.ExcCode_M = v.code;
    bus.EXLClr    = v.eret;
    bus.HWInt     = v.hw;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    // rst a1 we a2 din pc bd exc code eret hw | req dout epc ck
    add(0,  0,0, 0,32'h0,        32'h3010,0,1,12,0,6'h00, 0,32'h0,        32'h0,    3'b011);
    add(0, 12,0, 0,32'h0,        32'h3010,0,1,12,0,6'h00, 0,32'h0000_FC01,32'h0,    3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h0000_FC01,32'h0,    3'b111);
    add(1, 15,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h4255_4141,32'h0,    3'b111);
    add(1, 13,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h0,        32'h0,    3'b111);
    add(1,  0,0, 0,32'h0,        32'h3010,0,1,12,0,6'h00, 1,32'h0,        32'h0,    3'b111);
    add(1, 13,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h30,       32'h3010, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h0000_FC03,32'h3010, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,1,6'h00, 0,32'h0000_FC03,32'h3010, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h3024,1,1,10,0,6'h00, 1,32'h0000_FC01,32'h3010, 3'b111);
    add(1, 13,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h8000_0028,32'h3020, 3'b111);
    add(1, 14,0, 0,32'h0,        32'h0,   0,0, 0,1,6'h00, 0,32'h3020,     32'h3020, 3'b111);
    add(1,  0,0, 0,32'h0,        32'h3040,0,0, 0,0,6'h00, 0,32'h0,        32'h3020, 3'b111);
    add(1,  0,0, 0,32'h0,        32'h0,   0,1, 4,0,6'h04, 1,32'h0,        32'h3020, 3'b111);
    add(1, 13,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h04, 0,32'h0000_1000,32'h3040, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h3050,0,1,12,0,6'h3F, 0,32'h0000_FC03,32'h3040, 3'b111);
    add(1, 14,0, 0,32'h0,        32'h0,   0,0, 0,1,6'h3F, 0,32'h3040,     32'h3040, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h3F, 1,32'h0000_FC01,32'h3040, 3'b111);
    add(1, 14,0, 0,32'h0,        32'h0,   0,0, 0,1,6'h00, 0,32'h3050,     32'h3050, 3'b111);
    add(1,  0,1,14,32'h5000,     32'h3008,0,1,12,0,6'h00, 1,32'h0,        32'h3050, 3'b111);
    add(1, 14,0, 0,32'h0,        32'h0,   0,0, 0,1,6'h00, 0,32'h3008,     32'h3008, 3'b111);
    add(1, 14,1,14,32'h5000,     32'h0,   0,0, 0,0,6'h00, 0,32'h3008,     32'h3008, 3'b111);
    add(1, 14,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h5000,     32'h5000, 3'b111);
    add(1, 12,1,12,32'h400,      32'h0,   0,0, 0,0,6'h00, 0,32'h0000_FC01,32'h5000, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h02, 0,32'h400,      32'h5000, 3'b111);
    add(1, 12,1,12,32'hFFFF_FFFF,32'h0,   0,0, 0,0,6'h00, 0,32'h400,      32'h5000, 3'b111);
    add(1, 12,1,12,32'h403,      32'h0,   0,0, 0,1,6'h3F, 0,32'h0000_FC03,32'h5000, 3'b111);
    add(1, 12,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h02, 0,32'h401,      32'h5000, 3'b111);
    add(1,  0,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h01, 1,32'h0,        32'h5000, 3'b111);
    add(1, 13,1,13,32'hFFFF_FFFF,32'h0,   0,0, 0,0,6'h00, 0,32'h400,      32'h3008, 3'b111);
    add(1, 31,1,15,32'hFFFF_FFFF,32'h0,   0,0, 0,0,6'h00, 0,32'h0,        32'h3008, 3'b111);
    add(1, 13,0, 0,32'h0,        32'h0,   0,0, 0,0,6'h00, 0,32'h0,        32'h3008, 3'b111);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vq[i]);
      @(negedge clk);
      if (vq[i].ck[0]) chk("int_req", i, {31'd0, bus.IntReq}, {31'd0, vq[i].req});
      if (vq[i].ck[1]) chk("dout", i, bus.DOut, vq[i].dout);
      if (vq[i].ck[2]) chk("epc_out", i, bus.EPC_out, vq[i].epc);
      if (vq[i].req) chk("npc_exc", i, bus.NPC_Exc, 32'h0000_4180);
    end

    // EXL is set here; eret first, then a pending exception must be suppressed by reset.
    v = vq[0];
    v.rst = 1'b1; v.exc = 1'b0; v.eret = 1'b1; v.a1 = 5'd0;
    @(posedge clk); #1; drive(v);
    v.eret = 1'b0; v.exc = 1'b1; v.pc = 32'h3100;
    @(posedge clk); #1; drive(v);
    @(negedge clk);
    chk("seq_exc_live", 100, {31'd0, bus.IntReq}, 32'd1);
    v.rst = 1'b0;
    drive(v);
    #1;
    chk("seq_rst_gate", 101, {31'd0, bus.IntReq}, 32'd0);
    @(posedge clk); #1;
    v.rst = 1'b1; v.exc = 1'b0; v.pc = 32'h0; v.a1 = 5'd12;
    drive(v);
    @(negedge clk);
    chk("seq_rst_sr", 102, bus.DOut, 32'h0000_FC01);
    chk("seq_rst_epc", 103, bus.EPC_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 block in the MIPS pipeline, located at the M stage.
- Consumes the merged exception flag and code produced by the per-stage exception detectors (F/D/E/M codes travel down the pipeline and merge at M), together with external hardware interrupts.
- Decides whether to take an exception or interrupt, and produces the flush/redirect request.
- Holds SR, Cause, EPC and PrID, services mfc0/mtc0 accesses and eret.

Parameters:
- PRID, 32'h4255_4141, constant value read from PrID (reg 15).
- HANDLER_PC, 32'h0000_4180, exception vector output while IntReq is high.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 clears state on the rising edge of clk).
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- PC_M  in  32  PC of the M-stage instruction; 0 marks a bubble.
- BD_M  in  1  M-stage instruction sits in a branch delay slot.
- Exc_M  in  1  merged synchronous exception flag for the M-stage instruction.
- ExcCode_M  in  5  merged exception code (AdEL=4, AdES=5, RI=10, Ov=12).
- EXLClr  in  1  eret in M stage.
- HWInt  in  6  external interrupt lines [7:2].
- IntReq  out  1  take exception/interrupt this cycle; flushes the pipeline.
- NPC_Exc  out  32  HANDLER_PC.
- EPC_out  out  32  current EPC register, used by eret.
- DOut  out  32  mfc0 read data.

Behaviour:
- Register fields:
  - SR: IM=[15:10], EXL=[1], IE=[0].
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2].
  - All other bits read 0.
- Reset (reset==0 at a clk edge):
  - SR=32'h0000_FC01 (IM all set, IE=1, EXL=0).
  - Cause=0, EPC=0, last_pc=32'h0000_3000, last_bd=0.
  - PrID is constant.
- Outputs are combinational:
  - IntReq: int_pend = |(HWInt & SR.IM) & SR.IE & !SR.EXL; exc_pend = Exc_M & !SR.EXL; IntReq = int_pend | exc_pend.
  - Reset forces IntReq=0 in the same cycle.
- Priority: interrupt beats synchronous exception. ExcCode written is 0 when int_pend is set, otherwise ExcCode_M.
- Bubble tracking:
  - On every clk edge with PC_M!=0, last_pc<=PC_M and last_bd<=BD_M.
  - Effective pc_eff = (PC_M!=0) ? PC_M : last_pc.
  - Effective bd_eff = (PC_M!=0) ? BD_M : last_bd.
  - Purpose: an interrupt arriving during a bubble still records a valid return address.
- On a clk edge with IntReq=1:
  - EXL<=1.
  - Cause.BD<=bd_eff.
  - Cause.ExcCode<=selected code.
  - EPC<={epc_raw[31:2],2'b00}, where epc_raw = bd_eff ? pc_eff-4 : pc_eff.
  - Any simultaneous mtc0 (WE) is discarded.
- mtc0 (WE=1, IntReq=0):
  - A2=12 writes IM/EXL/IE from DIn.
  - A2=14 writes EPC from DIn (full 32 bits).
  - A2=13 and 15 are ignored.
  - Writes are visible on the next cycle; mfc0 in the same cycle reads the old value (no bypass).
- eret (EXLClr=1): EXL<=0 at the edge.
  - If WE to SR occurs in the same cycle, apply the write first, then clear EXL.
  - IntReq cannot co-occur while EXL=1.
- Cause.IP<=HWInt on every edge, regardless of masks and EXL; it is not writable.
- DOut selection: A1=12 SR, 13 Cause, 14 EPC, 15 PRID, any other value 0.
- Nested events: while EXL=1, all exceptions and interrupts are masked and EPC is preserved.
- Latency: the request is combinational in cycle N; register updates land at the edge ending cycle N; the handler fetch follows.

Decomposition:
- Shared macro header (existing macro.v) gains:
  - CP0 register numbers (SR=12, Cause=13, EPC=14, PrID=15).
  - Field bit positions.
  - ExcCode constants Int=0, AdEL, AdES, RI, Ov.
- One sub-module, cp0_int_arbiter:
  - Purely combinational.
  - Computes int_pend, exc_pend, IntReq, the selected ExcCode and the aligned EPC value from pc_eff/bd_eff.
- Register state stays in cp0_exception_unit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with Exc_M=1 → IntReq=0. Release, then mfc0 A1=12 → DOut=32'h0000_FC01; A1=15 → DOut=PRID.
- Exception: Exc_M=1, ExcCode_M=12, PC_M=32'h0000_3010, BD_M=0 → IntReq=1, NPC_Exc=32'h0000_4180. Next cycle: EPC_out=32'h0000_3010, Cause[6:2]=12, SR.EXL=1.
- Delay slot: Exc_M=1, ExcCode_M=10, PC_M=32'h0000_3024, BD_M=1 → EPC=32'h0000_3020, Cause[31]=1.
- Interrupt in bubble:
  - Stimulus: PC_M=32'h0000_3040 for one cycle, then PC_M=0 with HWInt=6'b000100 and Exc_M=1 (ExcCode 4).
  - Required: IntReq=1, Cause.ExcCode=0, EPC=32'h0000_3040, Cause[12]=1.
- Masking and eret:
  - While EXL=1, assert HWInt=6'h3F and Exc_M=1 → IntReq=0 and EPC unchanged.
  - Then EXLClr=1 → next cycle SR.EXL=0 and IntReq=1.
- mtc0 conflict:
  - WE=1, A2=14, DIn=32'h0000_5000 in the same cycle as Exc_M=1 at PC 32'h0000_3008 → EPC=32'h0000_3008 (write dropped).
  - Repeat with Exc_M=0 → EPC=32'h0000_5000 next cycle; same-cycle mfc0 A1=14 returns the old value.
